gf_mul_arbiter: RTL and testbench
=================================

Name: gf_mul_arbiter

Overview:
- Shares one combinational GF(2^8) multiplier (gf_mul or gf_mul_lut, instantiated outside this block) between NREQ requesters, e.g. the syndrome, key-equation and Chien/Forney stages of rsdec.
- Arbitrates requests round-robin and drives the selected operands to the shared multiplier.
- Registers the product, tagged with the requester ID, into a single output stage with a valid/ready handshake.
- Field arithmetic belongs to the attached multiplier. This block never computes GF products.

Parameters:
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), width of the requester ID

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  request pending, bit i = requester i
- req_a  in  NREQ*8  operand a, requester i occupies bits [8i+7:8i]
- req_b  in  NREQ*8  operand b, same packing as req_a
- req_ready  out  NREQ  one-hot accept strobe; transfer occurs on req_valid[i] & req_ready[i]
- mul_a  out  8  operand a to the shared multiplier
- mul_b  out  8  operand b to the shared multiplier
- mul_z  in  8  product from the shared multiplier (combinational)
- rsp_valid  out  1  output register holds a result
- rsp_ready  in  1  consumer accepts the result
- rsp_z  out  8  product
- rsp_id  out  IDW  index of the requester that owns rsp_z
- busy_cnt  out  16  count of accepted requests since reset, saturating at 16'hFFFF

Behaviour:
- Reset (rst=1 at posedge):
  - rsp_valid=0, rsp_z=0, rsp_id=0, busy_cnt=0, round-robin pointer ptr=0.
  - req_ready is forced to 0 while rst=1.
  - Reset mid-operation drops any held result. No response is issued for it.
- can_accept = !rsp_valid | rsp_ready. The output stage is empty, or it is being drained this cycle.
- Grant (combinational): g = first index i in ptr, ptr+1, ..., wrapping mod NREQ, with req_valid[i]=1.
- Accept condition: can_accept & |req_valid. When it holds:
  - req_ready[g]=1 and all other req_ready bits are 0.
  - If there is no valid request or can_accept=0, req_ready=0.
- mul_a/mul_b = req_a/req_b slice of g whenever any req_valid is set, otherwise 0. They are purely combinational, so no multiplier latency is budgeted.
- On accept at posedge:
  - rsp_z<=mul_z, rsp_id<=g, rsp_valid<=1.
  - ptr<=(g+1) mod NREQ.
  - busy_cnt increments unless already at 16'hFFFF.
- Latency: request accepted at edge N gives rsp_valid=1 after edge N.
- Throughput: one result per cycle while rsp_ready=1.
- Drain without accept (rsp_valid & rsp_ready & no request): rsp_valid<=0. rsp_z and rsp_id hold their last value.
- Simultaneous drain and accept: the new result replaces the old one in the same edge. No bubble, no loss.
- Back-pressure (rsp_valid=1, rsp_ready=0):
  - req_ready=0, ptr frozen.
  - rsp_z and rsp_id stable until handshake.
- Requester protocol:
  - Requesters keep req_valid, req_a and req_b stable until accepted.
  - Deasserting req_valid before accept is allowed. The request is simply not served.
  - The arbiter does not latch unaccepted operands.
- Fairness: a continuously asserted requester is granted within NREQ accepts. No starvation.
- ptr is unchanged by cycles with no accept.
- A single active requester is accepted every cycle, with ptr wrapping past it.

Test Plan (bench instantiates gf_mul, field poly 0x11D, wired to mul_a/mul_b/mul_z):
1. Reset: rst=1 for 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, busy_cnt=0. After release, first grant goes to requester 0.
2. Single request: req0 a=2, b=3, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_z=6, rsp_id=0, busy_cnt=1. Also run req2 a=0x80, b=2 -> rsp_z=0x1D, rsp_id=2. Also run req1 a=0, b=197 -> rsp_z=0.
3. Round-robin: all four requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1..., one result per cycle, every rsp_z matches the bench gf_mul model.
4. Back-pressure: rsp_ready=0 for 5 cycles with req1 and req3 pending -> rsp_valid stays 1, rsp_z and rsp_id frozen, req_ready=0. On rsp_ready=1 the next grant follows the frozen ptr.
5. Simultaneous drain and accept: rsp_valid=1, rsp_ready=1, req3 valid -> the next cycle shows req3's product with no idle cycle. Total response count equals busy_cnt.
6. Reset mid-operation: assert rst while rsp_valid=1 and rsp_ready=0 -> the held result is discarded, rsp_valid=0, ptr=0, busy_cnt=0.

Source files
------------

// File: rtl/gf_mul_arbiter.sv
// gf_mul_arbiter: round-robin arbiter sharing one external combinational
// GF(2^8) multiplier between NREQ requesters. The product is registered,
// tagged with the owning requester ID, behind a valid/ready output stage.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_a/req_b per-requester request and operands (8 bits each, packed)
//   req_ready             one-hot accept strobe (combinational)
//   mul_a/mul_b/mul_z     operands to / product from the shared multiplier
//   rsp_valid/rsp_ready   output handshake
//   rsp_z/rsp_id          registered product and owning requester index
//   busy_cnt              accepted requests since reset, saturating
module gf_mul_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*8-1:0]     req_a,
  input  logic [NREQ*8-1:0]     req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [7:0]            mul_a,
  output logic [7:0]            mul_b,
  input  logic [7:0]            mul_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [7:0]            rsp_z,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           busy_cnt
);

  localparam int unsigned DW      = 8;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_z_q, rsp_z_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    busy_cnt_q, busy_cnt_d;

  logic [IDW-1:0] grant_c;
  logic [IDW-1:0] idx_c;
  logic           found_c;
  logic           any_valid_c;
  logic           can_accept_c;
  logic           accept_c;

  assign any_valid_c  = |req_valid;
  assign can_accept_c = !rsp_valid_q || rsp_ready;
  assign accept_c     = can_accept_c && any_valid_c && !rst;

  // First valid requester scanning from ptr upward with wrap-around.
  always_comb begin
    grant_c = '0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = IDW'((32'(ptr_q) + k) % NREQ);
      if (!found_c && req_valid[idx_c]) begin
        found_c = 1'b1;
        grant_c = idx_c;
      end
    end
  end

  // Operand mux to the shared multiplier; zero when nobody is requesting.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (any_valid_c) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant_c == IDW'(i)) begin
          mul_a = req_a[i*DW +: DW];
          mul_b = req_b[i*DW +: DW];
        end
      end
    end
  end

  // One-hot accept strobe.
  always_comb begin
    req_ready = '0;
    if (accept_c) begin
      req_ready[grant_c] = 1'b1;
    end
  end

  // Next state of the output stage, pointer and counter.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_id_d    = rsp_id_q;
    busy_cnt_d  = busy_cnt_q;
    if (accept_c) begin
      rsp_valid_d = 1'b1;
      rsp_z_d     = mul_z;
      rsp_id_d    = grant_c;
      ptr_d       = (grant_c == IDW'(NREQ - 1)) ? '0 : grant_c + IDW'(1);
      if (busy_cnt_q != CNT_MAX) begin
        busy_cnt_d = busy_cnt_q + 16'd1;
      end
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_id_q    <= '0;
      busy_cnt_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_id_q    <= rsp_id_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = rsp_id_q;
  assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_gf_mul_arbiter.sv
// Directed bench for gf_mul_arbiter with a GF(2^8) multiplier (poly 0x11D)
// modelled in the bench and wired to mul_a/mul_b/mul_z.
module tb_gf_mul_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic [NREQ-1:0] req_ready;
  logic [7:0]      mul_a;
  logic [7:0]      mul_b;
  logic [7:0]      mul_z;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_z;
  logic [IDW-1:0]  rsp_id;
  logic [15:0]     busy_cnt;

  int n_cmp;
  int n_err;
  int n_rsp;

  gf_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id),
    .busy_cnt  (busy_cnt)
  );

  // Shift-and-add GF(2^8) multiply, field polynomial 0x11D.
  function automatic logic [7:0] gf_mul_f(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  assign mul_z = gf_mul_f(mul_a, mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  // Expect a fresh response after the next edge.
  task automatic step_rsp(input string tag, input logic [1:0] id, input logic [7:0] z);
    step();
    n_rsp++;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
    chk({tag, "_z"},     32'(rsp_z),     32'(z));
    chk({tag, "_cnt"},   32'(busy_cnt),  32'(n_rsp));
  endtask

  logic [1:0] rr_id [6];
  logic [7:0] rr_z  [6];

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_rsp = 0;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // 1. Reset with all requesters valid
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    repeat (3) step();
    chk("rst_ready2", 32'(req_ready), 32'h0);
    chk("rst_valid",  32'(rsp_valid), 32'h0);
    chk("rst_cnt",    32'(busy_cnt),  32'h0);
    chk("rst_z",      32'(rsp_z),     32'h0);
    rst = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'b0001);

    // 2. Single requests
    req_valid = 4'b0001;
    set_op(0, 8'h02, 8'h03);
    #1;
    chk("s0_ready", 32'(req_ready), 32'b0001);
    step_rsp("s0", 2'd0, 8'h06);

    req_valid = 4'b0100;
    set_op(2, 8'h80, 8'h02);
    #1;
    chk("s2_ready", 32'(req_ready), 32'b0100);
    chk("s2_mula",  32'(mul_a),     32'h80);
    chk("s2_mulb",  32'(mul_b),     32'h02);
    step_rsp("s2", 2'd2, 8'h1D);

    req_valid = 4'b0010;
    set_op(1, 8'h00, 8'd197);
    #1;
    chk("s1_ready", 32'(req_ready), 32'b0010);
    step_rsp("s1", 2'd1, 8'h00);

    // Drain with nothing pending: valid drops, data holds
    req_valid = 4'b0000;
    #1;
    chk("idle_mula", 32'(mul_a), 32'h0);
    step();
    chk("drain_valid", 32'(rsp_valid), 32'h0);
    chk("drain_z",     32'(rsp_z),     32'h00);
    chk("drain_id",    32'(rsp_id),    32'h1);

    // 3. Round-robin, pointer now at 2
    set_op(0, 8'h02, 8'h8E);
    set_op(1, 8'h03, 8'h03);
    set_op(2, 8'h04, 8'h40);
    set_op(3, 8'h10, 8'h10);
    rr_id[0] = 2'd2; rr_z[0] = 8'h1D;
    rr_id[1] = 2'd3; rr_z[1] = 8'h1D;
    rr_id[2] = 2'd0; rr_z[2] = 8'h01;
    rr_id[3] = 2'd1; rr_z[3] = 8'h05;
    rr_id[4] = 2'd2; rr_z[4] = 8'h1D;
    rr_id[5] = 2'd3; rr_z[5] = 8'h1D;
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step_rsp($sformatf("rr%0d", i), rr_id[i], rr_z[i]);
    end

    // 4. Back-pressure with req1 and req3 pending, pointer at 0
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'h0);
      step();
      chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp%0d_z", i),     32'(rsp_z),     32'h1D);
      chk($sformatf("bp%0d_id", i),    32'(rsp_id),    32'h3);
      chk($sformatf("bp%0d_cnt", i),   32'(busy_cnt),  32'(n_rsp));
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(req_ready), 32'b0010);
    step_rsp("bp_rel", 2'd1, 8'h05);

    // 5. Simultaneous drain and accept of req3
    req_valid = 4'b1000;
    #1;
    chk("da_ready", 32'(req_ready), 32'b1000);
    step_rsp("da", 2'd3, 8'h1D);
    chk("da_total", 32'(busy_cnt), 32'd11);

    // 6. Reset while a result is held under back-pressure
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    step();
    chk("hold_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("mrst_ready", 32'(req_ready), 32'h0);
    step();
    chk("mrst_valid", 32'(rsp_valid), 32'h0);
    chk("mrst_cnt",   32'(busy_cnt),  32'h0);
    chk("mrst_id",    32'(rsp_id),    32'h0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    n_rsp = 0;
    #1;
    chk("mrst_ptr", 32'(req_ready), 32'b0001);
    step_rsp("mrst_first", 2'd0, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
